// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128/192/256 key schedule: one expanded word per cycle into a round-key store.
// Optional AES_KEY_SCHED_DEC_ORDER_EN adds rd_dec for decryption-order round-key reads.
module aes_key_sched_iter #(
  parameter bit          READ_REG     = 1'b1,
  parameter int unsigned RK_DEPTH     = 15,
  parameter bit          CLR_ON_START = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   algorithm,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic         err,
`ifdef AES_KEY_SCHED_DEC_ORDER_EN
  input  logic         rd_dec,
`endif
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam int unsigned NumWords = RK_DEPTH * 4;
  localparam int unsigned IdxW     = $clog2(NumWords);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map; inverse of 0 falls out as 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] a);
    case (a)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] a);
    case (a)
      2'b00:   return 4'd10;
      2'b01:   return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [IdxW-1:0] last_of(input logic [1:0] a);
    case (a)
      2'b00:   return IdxW'(43);
      2'b01:   return IdxW'(51);
      default: return IdxW'(59);
    endcase
  endfunction

  state_e          state_q;
  logic [1:0]      alg_q;
  logic [IdxW-1:0] cnt_q;
  logic [2:0]      j_q;
  logic [7:0]      rcon_q;
  logic            busy_q, done_q, ready_q, err_q;
  logic [31:0]     w_q [NumWords];

  logic [3:0]      nk;
  logic [IdxW-1:0] prev_idx, back_idx;
  logic [31:0]     w_prev, w_back, sub_in, sub_out, t_word, w_new;

  assign nk       = nk_of(alg_q);
  assign prev_idx = cnt_q - IdxW'(1);
  assign back_idx = cnt_q - IdxW'(nk);

  // Single SubWord datapath shared by the RotWord/Rcon step and the AES-256 mid-block step.
  always_comb begin
    w_prev  = w_q[prev_idx];
    w_back  = w_q[back_idx];
    sub_in  = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = '0;
    for (int b = 0; b < 4; b++) sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
    if (j_q == 3'd0)                    t_word = sub_out ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && j_q == 3'd4) t_word = sub_out;
    else                                t_word = w_prev;
    w_new = w_back ^ t_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      alg_q   <= 2'b00;
      cnt_q   <= '0;
      j_q     <= 3'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < NumWords; k++) w_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            if (algorithm == 2'b11) begin
              err_q <= 1'b1;
            end else begin
              if (CLR_ON_START) begin
                for (int k = 0; k < NumWords; k++) w_q[k] <= '0;
              end
              for (int k = 0; k < 8; k++) begin
                if (k < int'(nk_of(algorithm))) w_q[k] <= key[255-32*k -: 32];
              end
              alg_q   <= algorithm;
              cnt_q   <= IdxW'(nk_of(algorithm));
              j_q     <= 3'd0;
              rcon_q  <= 8'h01;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
              state_q <= StExpand;
            end
          end
        end
        StExpand: begin
          w_q[cnt_q] <= w_new;
          j_q <= (j_q == 3'(nk - 4'd1)) ? 3'd0 : j_q + 3'd1;
          if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (cnt_q == last_of(alg_q)) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + IdxW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ready = ready_q;
  assign err   = err_q;

  logic [3:0]      nr, rd_idx;
  logic [IdxW-1:0] rd_base;
  logic [127:0]    rd_val;

  // Range check uses the raw rd_round so mapped decryption reads never alias past Nr.
  always_comb begin
    nr = nr_of(alg_q);
`ifdef AES_KEY_SCHED_DEC_ORDER_EN
    rd_idx = rd_dec ? nr - rd_round : rd_round;
`else
    rd_idx = rd_round;
`endif
    rd_base = IdxW'({rd_idx, 2'b00});
    rd_val  = '0;
    if (ready_q && rd_round <= nr && 32'(rd_idx) < RK_DEPTH) begin
      rd_val = {w_q[rd_base], w_q[rd_base + IdxW'(1)],
                w_q[rd_base + IdxW'(2)], w_q[rd_base + IdxW'(3)]};
    end
  end

  if (READ_REG) begin : g_rd_reg
    logic [127:0] rd_key_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_key_q <= '0;
      else     rd_key_q <= rd_val;
    end
    assign rd_key = rd_key_q;
  end else begin : g_rd_comb
    assign rd_key = rd_val;
  end

endmodule
